// File: rtl/cache_mem_bridge_pkg.sv
// Shared types and sizing for the cache-to-RAM block bridge.
// Block geometry follows the cache; only the RAM latency is set per instance.
package cache_mem_bridge_pkg;

  localparam int BLOCK_SIZE   = 4;
  localparam int WORD_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);

  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef word_t [BLOCK_SIZE-1:0] block_t;

  typedef struct packed {
    addr_t  addr;
    logic   cs;
    logic   rw;
    block_t data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [1:0] {br_idle, br_write, br_read, br_done} bridge_state_t;

  // Clears the word-offset bits so every transfer starts on a block boundary.
  function automatic addr_t block_base(input addr_t addr);
    return addr & ~addr_t'(BLOCK_SIZE - 1);
  endfunction

endpackage

// File: rtl/cache_mem_bridge_if.sv
// Block request/response channel between the cache controller and the bridge.
// The cache drives the request (master); the bridge answers (slave).
interface cache_mem_bridge_if;
  import cache_mem_bridge_pkg::*;

  memory_request_t  mem_req;
  memory_response_t mem_resp;

  modport master (output mem_req, input mem_resp);
  modport slave  (input mem_req, output mem_resp);

endinterface

// File: rtl/cache_mem_bridge.sv
// Serialises one block-wide cache request into BLOCK_SIZE single-word RAM
// accesses and gathers read data back into a block response.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cache_mem_bridge_if.slave        mem,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic [WORD_WIDTH-1:0]    ram_wdata,
  input  logic [WORD_WIDTH-1:0]    ram_rdata
);

  localparam int CNT_WIDTH = $clog2(BLOCK_SIZE + RAM_LATENCY) + 1;
  localparam int IDX_W     = OFFSET_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] NUM_WORDS = CNT_WIDTH'(BLOCK_SIZE);

  bridge_state_t          state_q, state_d;
  addr_t                  base_q;
  block_t                 wdata_q;
  block_t                 rdata_q;
  logic [CNT_WIDTH-1:0]   issue_q, issue_d;
  logic [CNT_WIDTH-1:0]   capt_q, capt_d;
  logic [RAM_LATENCY-1:0] valid_q;

  logic accept;
  logic issue_rd;
  logic capture;

  assign accept  = (state_q == br_idle) && mem.mem_req.cs;
  // Oldest bit of the valid pipe marks the cycle in which ram_rdata is ours.
  assign capture = valid_q[RAM_LATENCY-1];

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    capt_d    = capt_q;
    issue_rd  = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    unique case (state_q)
      br_idle: begin
        if (mem.mem_req.cs) begin
          issue_d = '0;
          capt_d  = '0;
          state_d = mem.mem_req.rw ? br_write : br_read;
        end
      end

      br_write: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = base_q + addr_t'(issue_q);
        ram_wdata = wdata_q[issue_q[IDX_W-1:0]];
        issue_d   = issue_q + 1'b1;
        if (issue_q == LAST_IDX) state_d = br_done;
      end

      br_read: begin
        if (issue_q < NUM_WORDS) begin
          ram_cs   = 1'b1;
          ram_addr = base_q + addr_t'(issue_q);
          issue_rd = 1'b1;
          issue_d  = issue_q + 1'b1;
        end
        if (capture) begin
          capt_d = capt_q + 1'b1;
          if (capt_q == LAST_IDX) state_d = br_done;
        end
      end

      br_done: state_d = br_idle;

      default: state_d = br_idle;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= br_idle;
      issue_q <= '0;
      capt_q  <= '0;
      valid_q <= '0;
      base_q  <= '0;
      // NOTE: the data arrays are reset too: rdata_q is visible on the
      // response port and a reset must also discard a captured request.
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      capt_q  <= capt_d;
      valid_q <= (valid_q << 1) | RAM_LATENCY'(issue_rd);
      if (accept) begin
        base_q  <= block_base(mem.mem_req.addr);
        wdata_q <= mem.mem_req.data;
      end
      if (capture) rdata_q[capt_q[IDX_W-1:0]] <= ram_rdata;
    end
  end

  assign mem.mem_resp.ack  = (state_q == br_done);
  assign mem.mem_resp.data = rdata_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench: one bridge with RAM_LATENCY=1 and one with RAM_LATENCY=3,
// each attached to a small behavioural RAM.
module tb_cache_mem_bridge;
  import cache_mem_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cache_mem_bridge_if bus1();
  cache_mem_bridge_if bus3();

  logic  ram_cs1, ram_we1, ram_cs3, ram_we3;
  addr_t ram_addr1, ram_addr3;
  word_t ram_wdata1, ram_rdata1, ram_wdata3, ram_rdata3;

  cache_mem_bridge #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem(bus1),
    .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  cache_mem_bridge #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem(bus3),
    .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  // Behavioural RAMs; idle read slots return a poison word.
  word_t mem1 [256];
  word_t rd1;
  always @(posedge clk) begin
    if (ram_cs1 && ram_we1) mem1[ram_addr1[7:0]] <= ram_wdata1;
    rd1 <= (ram_cs1 && !ram_we1) ? mem1[ram_addr1[7:0]] : 32'hDEAD_BEEF;
  end
  assign ram_rdata1 = rd1;

  word_t mem3 [256];
  word_t rd3 [3];
  always @(posedge clk) begin
    if (ram_cs3 && ram_we3) mem3[ram_addr3[7:0]] <= ram_wdata3;
    rd3[0] <= (ram_cs3 && !ram_we3) ? mem3[ram_addr3[7:0]] : 32'hDEAD_BEEF;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign ram_rdata3 = rd3[2];

  // Per-cycle record of one transaction, cycle 1 = first cycle after acceptance.
  logic  obs_cs   [1:20];
  logic  obs_we   [1:20];
  addr_t obs_addr [1:20];
  word_t obs_wd   [1:20];

  function automatic block_t blk(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
    block_t b;
    b[0] = w0; b[1] = w1; b[2] = w2; b[3] = w3;
    return b;
  endfunction

  task automatic start(input bit sel, input addr_t a, input logic rw, input block_t d);
    @(negedge clk);
    if (sel) begin
      bus3.mem_req.addr = a; bus3.mem_req.rw = rw; bus3.mem_req.data = d; bus3.mem_req.cs = 1'b1;
    end else begin
      bus1.mem_req.addr = a; bus1.mem_req.rw = rw; bus1.mem_req.data = d; bus1.mem_req.cs = 1'b1;
    end
  endtask

  // Records RAM activity until ack (bounded). On ack the request is dropped,
  // or, with chain set, turned into a read of the same block with cs held.
  task automatic observe(input bit sel, input bit chain, input int chg_cyc, output int ack_at);
    logic a;
    ack_at = -1;
    for (int c = 1; c <= 20 && ack_at < 0; c++) begin
      @(negedge clk);
      obs_cs[c]   = sel ? ram_cs3 : ram_cs1;
      obs_we[c]   = sel ? ram_we3 : ram_we1;
      obs_addr[c] = sel ? ram_addr3 : ram_addr1;
      obs_wd[c]   = sel ? ram_wdata3 : ram_wdata1;
      a = sel ? bus3.mem_resp.ack : bus1.mem_resp.ack;
      if (c == chg_cyc) begin
        bus1.mem_req.addr = bus1.mem_req.addr ^ 32'h80;
        bus1.mem_req.data = ~bus1.mem_req.data;
        bus1.mem_req.rw   = ~bus1.mem_req.rw;
      end
      if (a) begin
        ack_at = c;
        if (chain) bus1.mem_req.rw = 1'b0;
        else if (sel) bus3.mem_req.cs = 1'b0;
        else bus1.mem_req.cs = 1'b0;
      end
    end
  endtask

  block_t blk_a, blk_b, blk_c, blk_d, blk_f;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus1.mem_resp.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus1.mem_resp.ack); end
    checks++; if ({ram_cs1, ram_we1} !== 2'b00) begin errors++; $display("FAIL reset_cs_we got %b exp 00", {ram_cs1, ram_we1}); end
    checks++; if (ram_addr1 !== '0 || ram_wdata1 !== '0) begin errors++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", ram_addr1, ram_wdata1); end
    checks++; if (bus1.mem_resp.data !== '0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", bus1.mem_resp.data); end
    checks++; if (ram_cs3 !== 1'b0 || bus3.mem_resp.ack !== 1'b0) begin errors++; $display("FAIL reset_dut3 got cs=%b ack=%b exp 0/0", ram_cs3, bus3.mem_resp.ack); end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    int ack_at;
    start(0, 32'h13, 1'b1, blk_a);
    observe(0, 0, 0, ack_at);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_cs[i+1] !== 1'b1 || obs_we[i+1] !== 1'b1 || obs_addr[i+1] !== addr_t'(32'h10 + i) || obs_wd[i+1] !== blk_a[i]) begin
        errors++;
        $display("FAIL write_beat%0d got cs=%b we=%b addr=%h wd=%h exp 1/1/%h/%h", i, obs_cs[i+1], obs_we[i+1], obs_addr[i+1], obs_wd[i+1], 32'h10 + i, blk_a[i]);
      end
    end
    checks++; if (ack_at !== 5) begin errors++; $display("FAIL write_ack_cycle got %0d exp 5", ack_at); end
    checks++; if (obs_cs[5] !== 1'b0) begin errors++; $display("FAIL write_done_cs got %b exp 0", obs_cs[5]); end
    @(negedge clk);
    checks++; if (bus1.mem_resp.ack !== 1'b0 || ram_cs1 !== 1'b0) begin errors++; $display("FAIL write_after_done got ack=%b cs=%b exp 0/0", bus1.mem_resp.ack, ram_cs1); end
    checks++; if (bus1.mem_resp.data !== '0) begin errors++; $display("FAIL write_resp_untouched got %h exp 0", bus1.mem_resp.data); end
  endtask

  task automatic test_read(input bit sel, input addr_t wr_addr, input addr_t rd_addr, input block_t d, input int exp_ack);
    int ack_at;
    addr_t base;
    base = wr_addr & ~addr_t'(3);
    start(sel, wr_addr, 1'b1, d);
    observe(sel, 0, 0, ack_at);
    checks++; if (ack_at !== 5) begin errors++; $display("FAIL rd%0d_preload_ack got %0d exp 5", sel, ack_at); end
    start(sel, rd_addr, 1'b0, blk_c);
    observe(sel, 0, 0, ack_at);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_cs[i+1] !== 1'b1 || obs_we[i+1] !== 1'b0 || obs_addr[i+1] !== base + addr_t'(i)) begin
        errors++;
        $display("FAIL rd%0d_issue%0d got cs=%b we=%b addr=%h exp 1/0/%h", sel, i, obs_cs[i+1], obs_we[i+1], obs_addr[i+1], base + addr_t'(i));
      end
    end
    checks++; if (obs_cs[5] !== 1'b0) begin errors++; $display("FAIL rd%0d_issue_stop got cs=%b exp 0", sel, obs_cs[5]); end
    checks++; if (ack_at !== exp_ack) begin errors++; $display("FAIL rd%0d_ack_cycle got %0d exp %0d", sel, ack_at, exp_ack); end
    checks++;
    if ((sel ? bus3.mem_resp.data : bus1.mem_resp.data) !== d) begin
      errors++;
      $display("FAIL rd%0d_data got %h exp %h", sel, sel ? bus3.mem_resp.data : bus1.mem_resp.data, d);
    end
  endtask

  task automatic test_back_to_back();
    int ack_at;
    start(0, 32'h40, 1'b1, blk_c);
    observe(0, 1, 0, ack_at);
    checks++; if (ack_at !== 5) begin errors++; $display("FAIL b2b_write_ack got %0d exp 5", ack_at); end
    @(negedge clk);
    checks++; if (ram_cs1 !== 1'b0 || bus1.mem_resp.ack !== 1'b0) begin errors++; $display("FAIL b2b_idle got cs=%b ack=%b exp 0/0", ram_cs1, bus1.mem_resp.ack); end
    observe(0, 0, 0, ack_at);
    checks++; if (obs_cs[1] !== 1'b1 || obs_we[1] !== 1'b0 || obs_addr[1] !== 32'h40) begin errors++; $display("FAIL b2b_first_read got cs=%b we=%b addr=%h exp 1/0/40", obs_cs[1], obs_we[1], obs_addr[1]); end
    checks++; if (ack_at !== 6) begin errors++; $display("FAIL b2b_read_ack got %0d exp 6", ack_at); end
    checks++; if (bus1.mem_resp.data !== blk_c) begin errors++; $display("FAIL b2b_data got %h exp %h", bus1.mem_resp.data, blk_c); end
  endtask

  task automatic test_reset_mid_read();
    int ack_at;
    bit saw;
    start(0, 32'h21, 1'b0, blk_a);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus1.mem_req.cs = 1'b0;
    #1;
    checks++; if ({ram_cs1, ram_we1, bus1.mem_resp.ack} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl got %b exp 000", {ram_cs1, ram_we1, bus1.mem_resp.ack}); end
    checks++; if (ram_addr1 !== '0 || ram_wdata1 !== '0) begin errors++; $display("FAIL midrst_addr got %h/%h exp 0/0", ram_addr1, ram_wdata1); end
    checks++; if (bus1.mem_resp.data !== '0) begin errors++; $display("FAIL midrst_data got %h exp 0", bus1.mem_resp.data); end
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus1.mem_resp.ack || ram_cs1) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_no_activity got 1 exp 0"); end
    start(0, 32'h40, 1'b0, blk_a);
    observe(0, 0, 0, ack_at);
    checks++; if (ack_at !== 6) begin errors++; $display("FAIL midrst_next_ack got %0d exp 6", ack_at); end
    checks++; if (bus1.mem_resp.data !== blk_c) begin errors++; $display("FAIL midrst_next_data got %h exp %h", bus1.mem_resp.data, blk_c); end
  endtask

  task automatic test_busy_change();
    int ack_at;
    start(0, 32'h50, 1'b1, blk_d);
    observe(0, 0, 2, ack_at);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_we[i+1] !== 1'b1 || obs_addr[i+1] !== addr_t'(32'h50 + i) || obs_wd[i+1] !== blk_d[i]) begin
        errors++;
        $display("FAIL busy_beat%0d got we=%b addr=%h wd=%h exp 1/%h/%h", i, obs_we[i+1], obs_addr[i+1], obs_wd[i+1], 32'h50 + i, blk_d[i]);
      end
    end
    checks++; if (ack_at !== 5) begin errors++; $display("FAIL busy_ack got %0d exp 5", ack_at); end
  endtask

  initial begin
    bus1.mem_req = '0;
    bus3.mem_req = '0;
    blk_a = blk(32'hA000_00A0, 32'hA111_00A1, 32'hA222_00A2, 32'hA333_00A3);
    blk_b = blk(32'hB000_00B0, 32'hB111_00B1, 32'hB222_00B2, 32'hB333_00B3);
    blk_c = blk(32'hC000_00C0, 32'hC111_00C1, 32'hC222_00C2, 32'hC333_00C3);
    blk_d = blk(32'hD000_00D0, 32'hD111_00D1, 32'hD222_00D2, 32'hD333_00D3);
    blk_f = blk(32'hF000_00F0, 32'hF111_00F1, 32'hF222_00F2, 32'hF333_00F3);

    test_reset();
    test_write();
    test_read(0, 32'h20, 32'h22, blk_b, 6);
    test_read(1, 32'h20, 32'h22, blk_b, 8);
    test_read(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, blk_f, 8);
    test_back_to_back();
    test_reset_mid_read();
    test_busy_change();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
